wishbone_classic_master: RTL and testbench

- Wishbone classic initiator that turns one command on a simple valid/ready interface into one single Wishbone classic bus cycle.
- Returns read data or status on a response valid/ready channel.
- Drives slaves such as wishbone_classic_uart from cores, bridges and debug paths.
- One outstanding transfer at a time; no bursts, no pipelined mode.

---
 rtl/wishbone_master_pkg.sv | 22 ++
 rtl/wb_master_timeout.sv | 34 +++
 rtl/wishbone_classic_master.sv | 168 ++++++++++++++++
 tb/tb_wishbone_classic_master.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wishbone_master_pkg.sv
// Purpose     : shared types and constants for the Wishbone initiators.
// Latency     : n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, default timeout length, response codes.
package wishbone_master_pkg;

  // Classic master FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_e;

  // Default number of BUS cycles before an unanswered cycle is aborted.
  localparam int unsigned WB_TIMEOUT_CYCLES_DEFAULT = 255;

  // Response classification, shared with a future pipelined master.
  localparam logic [1:0] WB_RSP_OK      = 2'd0;
  localparam logic [1:0] WB_RSP_BUS_ERR = 2'd1;
  localparam logic [1:0] WB_RSP_TIMEOUT = 2'd2;

endpackage

// File: rtl/wb_master_timeout.sv
// Purpose     : cycle counter that flags an unanswered Wishbone bus cycle.
// Latency     : expired is combinational from the registered count.
// Backpressure: none; counts whenever en is high, clr has priority.
// Ports: clk, rstn (sync, active-low), clr (restart count), en (count this
//        cycle), expired (high on the cycle whose edge would reach LIMIT).
module wb_master_timeout
  import wishbone_master_pkg::*;
#(
  parameter int unsigned LIMIT = WB_TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [15:0] count_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + 16'd1;
    end
  end

  // Flag on the edge that would bring the count to LIMIT, so the cycle is
  // held for exactly LIMIT unanswered BUS cycles.
  assign expired = en && (count_q == 16'(LIMIT - 1));

endmodule

// File: rtl/wishbone_classic_master.sv
// Purpose     : turns one valid/ready command into one Wishbone classic cycle.
// Latency     : bus visible 1 cycle after accept; rsp_valid >= 2 cycles after accept.
// Backpressure: one transfer in flight; rsp held until rsp_ready, cmd_ready low meanwhile.
// Ports: clk/rstn (sync active-low); cmd_* request channel; rsp_* response
//        channel; m_wb_* Wishbone classic initiator port.
// Option: define WB_MASTER_TIMEOUT_EN to abort cycles unanswered for
//         TIMEOUT_CYCLES bus cycles (reported as rsp_err).
module wishbone_classic_master
  import wishbone_master_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH  = 16,
  parameter int unsigned BUS_WIDTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = WB_TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_we,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [BUS_WIDTH*8-1:0]   cmd_wdata,
  input  logic [BUS_WIDTH-1:0]     cmd_sel,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [BUS_WIDTH*8-1:0]   rsp_rdata,
  output logic                     rsp_err,
  output logic                     m_wb_cyc,
  output logic                     m_wb_stb,
  output logic                     m_wb_we,
  output logic [ADDRESS_WIDTH-1:0] m_wb_addr,
  output logic [BUS_WIDTH*8-1:0]   m_wb_data_o,
  output logic [BUS_WIDTH-1:0]     m_wb_sel,
  input  logic                     m_wb_ack,
  input  logic [BUS_WIDTH*8-1:0]   m_wb_data_i,
  input  logic                     m_wb_err
);

  localparam int unsigned DW = BUS_WIDTH * 8;

  wb_state_e                state_q, state_d;
  logic                     cyc_q, cyc_d;
  logic                     stb_q, stb_d;
  logic                     we_q, we_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DW-1:0]            wdata_q, wdata_d;
  logic [BUS_WIDTH-1:0]     sel_q, sel_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]            rsp_rdata_q, rsp_rdata_d;
  logic                     rsp_err_q, rsp_err_d;
  logic                     accept;
  logic                     timeout_hit;

  assign cmd_ready = rstn && (state_q == IDLE);
  assign accept    = cmd_valid && cmd_ready;

`ifdef WB_MASTER_TIMEOUT_EN
  logic timeout_en;

  // Ack/err on the expiry edge keeps the counter from flagging, so a
  // late answer wins over the abort.
  assign timeout_en = (state_q == BUS) && !m_wb_ack && !m_wb_err;

  wb_master_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (accept),
    .en      (timeout_en),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = BUS;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = cmd_we;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          sel_d   = cmd_sel;
        end
      end
      BUS: begin
        if (m_wb_ack || m_wb_err) begin
          state_d     = RESP;
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          we_d        = 1'b0;
          rsp_valid_d = 1'b1;
          // err dominates ack; only clean reads return data.
          rsp_err_d   = m_wb_err;
          rsp_rdata_d = (!we_q && !m_wb_err) ? m_wb_data_i : '0;
        end else if (timeout_hit) begin
          state_d     = RESP;
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          we_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign m_wb_cyc    = cyc_q;
  assign m_wb_stb    = stb_q;
  assign m_wb_we     = we_q;
  assign m_wb_addr   = addr_q;
  assign m_wb_data_o = wdata_q;
  assign m_wb_sel    = sel_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_wishbone_classic_master.sv
// Purpose     : self-checking bench for wishbone_classic_master.
// Latency     : n/a.
// Backpressure: rsp_ready randomised, with a forced stall window.
// Honours WB_MASTER_TIMEOUT_EN (TIMEOUT_CYCLES = 8) when defined.
module tb_wishbone_classic_master;

  localparam int AW = 16;
  localparam int BW = 4;
  localparam int DW = 32;
  localparam int TO = 8;

  logic tb_data_clk = 1'b0;
  always #5 tb_data_clk = ~tb_data_clk;

  logic          rstn;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [BW-1:0] cmd_sel;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          m_wb_cyc, m_wb_stb, m_wb_we, m_wb_ack, m_wb_err;
  logic [AW-1:0] m_wb_addr;
  logic [DW-1:0] m_wb_data_o, m_wb_data_i;
  logic [BW-1:0] m_wb_sel;

  wishbone_classic_master #(
    .ADDRESS_WIDTH  (AW),
    .BUS_WIDTH      (BW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (tb_data_clk),
    .rstn        (rstn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_we      (cmd_we),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_sel     (cmd_sel),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .m_wb_cyc    (m_wb_cyc),
    .m_wb_stb    (m_wb_stb),
    .m_wb_we     (m_wb_we),
    .m_wb_addr   (m_wb_addr),
    .m_wb_data_o (m_wb_data_o),
    .m_wb_sel    (m_wb_sel),
    .m_wb_ack    (m_wb_ack),
    .m_wb_data_i (m_wb_data_i),
    .m_wb_err    (m_wb_err)
  );

  // One planned transfer: the command plus how the slave will answer it.
  typedef struct {
    bit          we;
    bit [AW-1:0] addr;
    bit [DW-1:0] wdata;
    bit [BW-1:0] sel;
    int          delay;
    bit          ack;
    bit          err;
    bit [DW-1:0] rdata;
    bit          aborted;
  } txn_t;

  typedef struct {
    bit          err;
    bit [DW-1:0] rdata;
  } rsp_t;

  txn_t plan_q[$];
  rsp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cycn = 0;
  int   hs_n = -10;
  bit   hold_ready = 1'b0;

  always @(posedge tb_data_clk) cycn <= cycn + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cycn);
    end
  endtask

  // Reference model: what the transfer should report back.
  function automatic rsp_t model(input txn_t t);
    rsp_t r;
    if (t.err || !t.ack) begin
      r.err   = 1'b1;     // bus error, or timeout when nothing answers
      r.rdata = '0;
    end else begin
      r.err   = 1'b0;
      r.rdata = t.we ? '0 : t.rdata;
    end
    return r;
  endfunction

  // Expected number of cycles cyc stays high.
  function automatic int bus_len(input txn_t t);
    return (t.ack || t.err) ? t.delay + 1 : TO;
  endfunction

  function automatic txn_t mk(input bit we, input bit [AW-1:0] addr, input bit [DW-1:0] wdata,
                              input bit [BW-1:0] sel, input int delay, input bit ack,
                              input bit err, input bit [DW-1:0] rdata);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wdata; t.sel = sel;
    t.delay = delay; t.ack = ack; t.err = err; t.rdata = rdata; t.aborted = 1'b0;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    int k;
    k = $urandom_range(0, 9);   // 0-7 ack, 8 err, 9 ack+err
    return mk(1'($urandom_range(0, 1)), 16'($urandom), $urandom, 4'($urandom),
              $urandom_range(0, 4), (k != 8), (k >= 8), $urandom);
  endfunction

  // Drive a command from a negedge until accepted; returns at the following negedge.
  task automatic send(input txn_t t, output int acc_n);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_we = t.we; cmd_addr = t.addr; cmd_wdata = t.wdata; cmd_sel = t.sel;
    while (!cmd_ready && n < 3000) begin
      @(negedge tb_data_clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++; failures++;
      $display("FAIL cmd_accept: cmd_ready=0 after %0d cycles, expected 1", n);
      cmd_valid = 1'b0;
      acc_n = -1;
      return;
    end
    acc_n = cycn;
    plan_q.push_back(t);
    if (!t.aborted) exp_q.push_back(model(t));
    @(negedge tb_data_clk);
    cmd_valid = 1'b0;
    cmd_we = 1'($urandom_range(0, 1)); cmd_addr = 16'($urandom);
    cmd_wdata = $urandom; cmd_sel = 4'($urandom);
    check("bus_start", {m_wb_cyc, m_wb_stb, m_wb_we, m_wb_addr, m_wb_data_o, m_wb_sel},
          {1'b1, 1'b1, t.we, t.addr, t.wdata, t.sel});
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge tb_data_clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  // Behavioural slave: answers each bus cycle as its plan says.
  initial begin
    txn_t p;
    int   len;
    m_wb_ack = 1'b0; m_wb_err = 1'b0; m_wb_data_i = '0;
    forever begin
      @(negedge tb_data_clk);
      if (m_wb_cyc === 1'b1) begin
        if (plan_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_cyc: cyc=1 with no command issued, expected 0");
          p = mk(0, 0, 0, 0, 0, 1'b1, 1'b0, 0);
          p.aborted = 1'b1;
        end else begin
          p = plan_q.pop_front();
        end
        len = 0;
        while (m_wb_cyc === 1'b1 && len < 1100) begin
          check("bus_hold", {m_wb_stb, m_wb_we, m_wb_addr, m_wb_data_o, m_wb_sel},
                {1'b1, p.we, p.addr, p.wdata, p.sel});
          if ((p.ack || p.err) && len == p.delay) begin
            m_wb_ack = p.ack; m_wb_err = p.err; m_wb_data_i = p.rdata;
          end else begin
            m_wb_ack = 1'b0; m_wb_err = 1'b0; m_wb_data_i = $urandom;
          end
          @(negedge tb_data_clk);
          len++;
        end
        m_wb_ack = 1'b0; m_wb_err = 1'b0;
        if (!p.aborted) check("bus_len", len, bus_len(p));
      end else begin
        // Stray answers outside a bus cycle must be ignored.
        m_wb_ack    = ($urandom_range(0, 3) == 0);
        m_wb_err    = ($urandom_range(0, 7) == 0);
        m_wb_data_i = $urandom;
      end
    end
  end

  // Response monitor / scoreboard.
  initial begin
    bit            prev_hs, prev_stall, prev_err;
    logic [DW-1:0] prev_rdata;
    rsp_t          e;
    prev_hs = 1'b0; prev_stall = 1'b0; prev_err = 1'b0; prev_rdata = '0;
    rsp_ready = 1'b0;
    forever begin
      @(negedge tb_data_clk);
      rsp_ready = hold_ready ? 1'b0 : ($urandom_range(0, 2) != 0);
      if (!rstn) begin
        prev_hs = 1'b0; prev_stall = 1'b0;
      end else begin
        if (prev_hs) check("post_hs", {rsp_valid, cmd_ready}, 2'b01);
        if (prev_stall) check("rsp_stable", {rsp_valid, rsp_err, rsp_rdata},
                              {1'b1, prev_err, prev_rdata});
        if (rsp_valid) check("cmd_ready_busy", cmd_ready, 0);
        prev_hs    = rsp_valid && rsp_ready;
        prev_stall = rsp_valid && !rsp_ready;
        prev_err   = rsp_err;
        prev_rdata = rsp_rdata;
        if (prev_hs) begin
          hs_n = cycn;
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_rsp: err=%0d rdata=0x%0h with none pending", rsp_err, rsp_rdata);
          end else begin
            e = exp_q.pop_front();
            check("rsp", {rsp_err, rsp_rdata}, {e.err, e.rdata});
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t, t2;
    int   acc, hi, n;
    rstn = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_sel = '0;
    repeat (3) @(negedge tb_data_clk);
    check("reset_bus", {m_wb_cyc, m_wb_stb, m_wb_we, m_wb_addr, m_wb_data_o, m_wb_sel}, 0);
    check("reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
    check("reset_cmd_ready", cmd_ready, 0);
    rstn = 1'b1;
    @(negedge tb_data_clk);
    check("idle_cmd_ready", cmd_ready, 1);
    check("idle_bus", {m_wb_cyc, m_wb_stb, rsp_valid}, 0);

    // Directed: write, delayed read, error priority, write error.
    send(mk(1, 16'h0004, 32'hAAAA0000, 4'hF, 1, 1, 0, 32'h5555_1111), acc);
    send(mk(0, 16'h0008, 32'h0, 4'hF, 3, 1, 0, 32'h12345678), acc);
    send(mk(0, 16'h0010, 32'h0, 4'hF, 0, 1, 1, 32'hDEAD_BEEF), acc);
    send(mk(1, 16'h0014, 32'h0BAD_0BAD, 4'h3, 2, 0, 1, 32'h7777_7777), acc);
    wait_drain();

    // Backpressure with a second command waiting.
    hold_ready = 1'b1;
    send(mk(0, 16'h0020, 32'h0, 4'hF, 0, 1, 0, 32'hCAFE_F00D), acc);
    t2 = mk(1, 16'h0024, 32'h0123_4567, 4'hC, 1, 1, 0, 32'h0);
    cmd_valid = 1'b1; cmd_we = t2.we; cmd_addr = t2.addr; cmd_wdata = t2.wdata; cmd_sel = t2.sel;
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge tb_data_clk);
      n++;
    end
    check("bp_rsp_valid", rsp_valid, 1);
    repeat (10) begin
      @(negedge tb_data_clk);
      check("bp_cmd_ready", cmd_ready, 0);
      check("bp_no_cyc", m_wb_cyc, 0);
    end
    hold_ready = 1'b0;
    send(t2, acc);
    check("bp_gap", acc, hs_n + 1);
    wait_drain();

    // Randomised traffic.
    for (int i = 0; i < 60; i++) begin
      t = rand_txn();
      send(t, acc);
      repeat ($urandom_range(0, 2)) @(negedge tb_data_clk);
    end
    wait_drain();

    // Unanswered cycle.
`ifdef WB_MASTER_TIMEOUT_EN
    send(mk(0, 16'h0030, 32'h0, 4'hF, 0, 0, 0, 32'h0), acc);
    wait_drain();
`else
    t = mk(0, 16'h0030, 32'h0, 4'hF, 0, 0, 0, 32'h0);
    t.aborted = 1'b1;
    send(t, acc);
    hi = 1;
    repeat (999) begin
      @(negedge tb_data_clk);
      if (m_wb_cyc) hi++;
    end
    check("no_timeout_cyc_high", hi, 1000);
    rstn = 1'b0;
    @(negedge tb_data_clk);
    check("rst_abort_long", {m_wb_cyc, m_wb_stb, rsp_valid}, 0);
    rstn = 1'b1;
    repeat (3) @(negedge tb_data_clk);
`endif

    // Reset in the middle of a bus cycle.
    t = mk(0, 16'h0040, 32'h0, 4'hF, 0, 0, 0, 32'h0);
    t.aborted = 1'b1;
    send(t, acc);
    @(negedge tb_data_clk);
    rstn = 1'b0;
    @(negedge tb_data_clk);
    check("rst_abort", {m_wb_cyc, m_wb_stb, rsp_valid}, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    rstn = 1'b1;
    repeat (20) @(negedge tb_data_clk);
    check("rst_no_pending", exp_q.size() + plan_q.size(), 0);

    // Recovery after reset.
    send(mk(0, 16'h0044, 32'h0, 4'h1, 2, 1, 0, 32'h600D_CAFE), acc);
    wait_drain();
    repeat (5) @(negedge tb_data_clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
